// File: rtl/seq_divider_8bit.sv
`timescale 1ns/1ps
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses the inverted divisor plus carry-in as the no-borrow test.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             last_iter;

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    div_by_zero = dz_q;
    quotient    = quot_q;
    remainder   = rem_q;
  end

  // A bit shifted out of A means the partial remainder already exceeds M.
  always_comb begin
    acc_sh    = {acc_q, quo_q[WIDTH-1]};
    trial     = {1'b0, acc_sh[WIDTH-1:0]} + {1'b0, ~m_q} + (WIDTH+1)'(1);
    no_borrow = acc_sh[WIDTH] | trial[WIDTH];
  end

  always_comb begin
    acc_d  = acc_q;
    quo_d  = quo_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    dz_d   = dz_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    done_d = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          quo_d = dividend;
          m_d   = divisor;
          acc_d = '0;
          cnt_d = '0;
          dz_d  = 1'b0;
        end
      end
      RUN: begin
        acc_d = no_borrow ? trial[WIDTH-1:0] : acc_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
        cnt_d = last_iter ? cnt_q : cnt_q + CW'(1);
      end
      DONE: begin
        dz_d   = (m_q == '0);
        quot_d = (m_q == '0) ? '1 : quo_q;
        rem_d  = (m_q == '0) ? quo_q : acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      quo_q  <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      quo_q  <= quo_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: tb/tb_seq_divider_8bit.sv
`timescale 1ns/1ps
// Scoreboard bench for seq_divider_8bit: directed vectors plus held-start random ops.
module tb_seq_divider_8bit;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_issued = 0;
  logic prev_done = 1'b0;

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      n_done++;
      chk("done_one_cycle", 16'(prev_done), 16'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 16'(done), 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 16'(quotient), 16'(e.q));
        chk("remainder", 16'(remainder), 16'(e.r));
        chk("div_by_zero", 16'(div_by_zero), 16'(e.dz));
      end
    end
    prev_done <= done;
  end

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r,
                          input logic dz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = dz;
    sb.push_back(e);
    n_issued++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 16'(busy), 16'd0);
  endtask

  task automatic wait_done(input int exp_lat, input int already);
    int n = already;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk("latency", 16'(n), 16'(exp_lat));
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input int lat);
    wait_idle();
    start = 1'b1;
    dividend = a;
    divisor = b;
    push_exp(eq, er, edz);
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    chk("busy_after_accept", 16'(busy), 16'd1);
    wait_done(lat, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    #1;
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_q", 16'(quotient), 16'd0);
    chk("reset_r", 16'(remainder), 16'd0);
    chk("reset_dz", 16'(div_by_zero), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
    issue(8'd250, 8'd200, 8'd1, 8'd50, 1'b0, 9);
    issue(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
    issue(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);

    // start and new operands during RUN must be ignored
    wait_idle();
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd13;
    push_exp(8'd15, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 8'd1;
    divisor = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_during_run", 16'(busy), 16'd1);
    wait_done(9, 4);

    // reset four clocks into an operation aborts it
    wait_idle();
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_abort", 16'(busy), 16'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_q", 16'(quotient), 16'd0);
    chk("abort_r", 16'(remainder), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", 16'(n_done), 16'(n_issued));
    issue(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9);

    // back-to-back random operations with start held high
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      wait_idle();
      dividend = a;
      divisor = b;
      if (b == 8'd0) push_exp(8'hFF, a, 1'b1);
      else push_exp(a / b, a % b, 1'b0);
      @(posedge clk);
      #1;
      if (i % 100 == 0) chk("busy_b2b", 16'(busy), 16'd1);
    end
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("done_count", 16'(n_done), 16'(n_issued));
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
